// File: rtl/hc_pkg.sv
// Shared types and helpers for the 74HC595 chain driver: FSM state encoding
// and the counter-width function used for the phase and bit counters.
package hc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      LATCH
   } state_t;

   // A modulus of 1 still needs a one-bit register to hold its single value.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hc595_driver_if.sv
// Word handshake between the control logic and the 74HC595 chain driver.
interface hc595_driver_if #(
   parameter int WIDTH = 8
) ();

   logic [WIDTH-1:0] Data;
   logic             Valid;
   logic             Ready;
   logic             Busy;

   modport master (output Data, output Valid, input Ready, input Busy);
   modport slave  (input Data, input Valid, output Ready, output Busy);

endinterface

// File: rtl/hc595_phase_cnt.sv
// Modulo-DIV phase counter with synchronous clear; o_tc marks the last
// system clock of every Sck half-period and of the Rck pulse.
module hc595_phase_cnt
   import hc_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic Clk,
   input  logic i_clr,
   output logic o_tc
);

   localparam int CW = cnt_w(DIV);

   logic [CW-1:0] r_cnt;

   assign o_tc = (r_cnt == CW'(DIV - 1));

   always_ff @(posedge Clk) begin
      if (i_clr || o_tc) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/hc595_driver.sv
// Shifts a WIDTH-bit word MSB first onto Ser/Sck, then pulses Rck to latch it
// into the 74HC595 output stage; every pin is driven straight from a flop.
module hc595_driver
   import hc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic           Clk,
   input  logic           Rst,
   hc595_driver_if.slave  bus,
   output logic           Ser,
   output logic           Sck,
   output logic           Rck,
   output logic           Oe_N
);

   localparam int BW = cnt_w(WIDTH);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt;
   logic [BW-1:0]    r_bit,   w_bit_nxt;
   logic             r_ser,   w_ser_nxt;
   logic             r_sck,   w_sck_nxt;
   logic             r_rck,   w_rck_nxt;
   logic             r_oe_n,  w_oe_n_nxt;
   logic             r_ready, w_ready_nxt;
   logic             r_busy,  w_busy_nxt;
   logic             w_tc;
   logic             w_clr;

   // The phase counter idles at zero so every frame starts on a fresh phase.
   assign w_clr = Rst || (r_state == IDLE);

   hc595_phase_cnt #(.DIV(DIV)) u_phase_cnt (
      .Clk   (Clk),
      .i_clr (w_clr),
      .o_tc  (w_tc)
   );

   always_comb begin
      // NOTE: every next-state value defaults to hold first, so no path through the case can infer a latch.
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      w_ser_nxt   = r_ser;
      w_sck_nxt   = r_sck;
      w_rck_nxt   = r_rck;
      w_oe_n_nxt  = r_oe_n;
      w_ready_nxt = r_ready;
      w_busy_nxt  = r_busy;

      case (r_state)
         IDLE: begin
            if (bus.Valid) begin
               w_shift_nxt = bus.Data;
               w_ser_nxt   = bus.Data[WIDTH-1];
               w_bit_nxt   = '0;
               w_ready_nxt = 1'b0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = LOW;
            end
         end
         LOW: begin
            if (w_tc) begin
               w_sck_nxt   = 1'b1;
               w_state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (w_tc) begin
               w_sck_nxt = 1'b0;
               if (r_bit != BW'(WIDTH - 1)) begin
                  w_shift_nxt = r_shift << 1;
                  w_ser_nxt   = w_shift_nxt[WIDTH-1];
                  w_bit_nxt   = r_bit + 1'b1;
                  w_state_nxt = LOW;
               end else begin
                  w_rck_nxt   = 1'b1;
                  w_ser_nxt   = 1'b0;
                  w_state_nxt = LATCH;
               end
            end
         end
         LATCH: begin
            if (w_tc) begin
               w_rck_nxt   = 1'b0;
               w_oe_n_nxt  = 1'b0;
               w_ready_nxt = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_ser   <= 1'b0;
         r_sck   <= 1'b0;
         r_rck   <= 1'b0;
         r_oe_n  <= 1'b1;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
         r_ser   <= w_ser_nxt;
         r_sck   <= w_sck_nxt;
         r_rck   <= w_rck_nxt;
         r_oe_n  <= w_oe_n_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign Ser       = r_ser;
   assign Sck       = r_sck;
   assign Rck       = r_rck;
   assign Oe_N      = r_oe_n;
   assign bus.Ready = r_ready;
   assign bus.Busy  = r_busy;

endmodule

// File: doc/hc595_driver.md
# hc595_driver

Parallel-to-serial driver for one 74HC595-style shift/latch register chain. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first on Ser/Sck. It then pulses Rck to latch the word into the receiver's output stage. It is the transmit end of the serial D-flip-flop chains the team models in its 74-series blocks, and sits between the control logic and the board-level register pins.

## Interface
- WIDTH, 8: bits per frame; legal range ≥1.
- DIV, 4: system clocks per Sck half-period and per Rck pulse; legal range ≥1.

- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Data  in  WIDTH  word to send; sampled only on accept.
- Valid  in  1  Data is valid.
- Ready  out  1  driver idle; accept occurs on an edge where Valid&&Ready.
- Busy  out  1  frame in progress (equals !Ready except during Rst).
- Ser  out  1  serial data to receiver SER.
- Sck  out  1  shift clock to receiver SRCLK.
- Rck  out  1  latch clock to receiver RCLK.
- Oe_N  out  1  receiver output enable, active-low.

## Operation
- All outputs are registered; no combinational input-to-output path.
- Reset values: Ser=0, Sck=0, Rck=0, Busy=0, Ready=1, Oe_N=1, state=IDLE, counters 0.
- While Rst=1, Valid is ignored and no accept occurs.
- State machine: IDLE, LOW, HIGH, LATCH. Div counter d runs 0..DIV-1 and bit counter b runs 0..WIDTH-1.
- IDLE: Ready=1. On Valid, load the shift register with Data, set Ser=Data[WIDTH-1], then go to LOW with d=0 and b=0.
- LOW: Sck=0. When d=DIV-1, go to HIGH, Sck←1, d←0.
- HIGH: Sck=1. When d=DIV-1:
  - If b<WIDTH-1: go to LOW, Sck←0, shift left, Ser←next bit, b←b+1.
  - Otherwise: go to LATCH, Sck←0, Rck←1, Ser←0.
- LATCH: Rck=1. When d=DIV-1, go to IDLE, Rck←0, Oe_N←0 (stays 0 until Rst), Ready←1.
- Valid while Busy is ignored. Data changes after accept have no effect.
- Ser is stable for DIV cycles before and DIV cycles after each Sck rising edge.
- Rck never overlaps Sck=1.

## Timing
- Accept edge is T0. Busy=1 and Ser=MSB from T0+1.
- Sck rising edge k (k=0..WIDTH-1) occurs at T0+DIV+2·DIV·k.
- Rck rises at T0+2·DIV·WIDTH and falls at T0+2·DIV·WIDTH+DIV.
- Ready returns 1 at T0+2·DIV·WIDTH+DIV. A new accept is possible on that same edge's following cycle (back-to-back frames, zero gap beyond IDLE's single cycle).
- Frame period with continuous Valid: 2·DIV·WIDTH+DIV+1 cycles. For WIDTH=8, DIV=4 this is 69.
- Rst mid-frame: the next edge returns every output to its reset value, including Oe_N=1. The partial frame is discarded and is never latched.
- DIV=1: Sck toggles every cycle, and Rck is a single-cycle pulse.

## Structure
- Shared package hc_pkg holds:
  - state enum {IDLE, LOW, HIGH, LATCH};
  - the helper function clog2-based counter widths for DIV and WIDTH.
- One sub-module, hc595_phase_cnt, is natural. It is a DIV-modulo counter with synchronous clear and a terminal-count output (d=DIV-1). The FSM uses that terminal count as its only phase-advance condition.
- The shift register, bit counter and FSM stay in hc595_driver.

## Test plan
- Reset: Rst=1 for 3 cycles then 0 → Ready=1, Busy=0, Ser=Sck=Rck=0, Oe_N=1; Valid during Rst produces no Sck edge.
- Single frame, WIDTH=8, DIV=4, Data=8'hA5 → bench-side 595 model samples Ser at each Sck rise and collects 1,0,1,0,0,1,0,1. Rck is high for cycles 64–67 after accept, the latched value equals 8'hA5, and Oe_N=0 from cycle 68.
- Back-to-back: Valid held high with 8'h01 then 8'hFF → second accept exactly 69 cycles after the first, and latched outputs read 8'h01 then 8'hFF.
- Valid while busy: Data=8'h3C accepted, then Valid pulsed with 8'hC3 at cycle 20 → only 8'h3C is latched, and Ready stays 0 until cycle 68.
- Mid-frame reset: Rst asserted at cycle 30 of a frame → all outputs return to reset values on the next edge, no Rck pulse occurs, and the next frame 8'h5A latches correctly.
- DIV=1, WIDTH=1, Data=1 → Ser=1 at T0+1, Sck high at T0+1, Rck high at T0+2, Ready at T0+3.
